// File: rtl/ws2812b_driver.sv
// rtl/ws2812b_driver.sv - WS2812B serialiser: snapshots mask/intensity once per frame and
// streams NUM_LEDS GRB words (MSB first) followed by a low latch gap.
module ws2812b_driver #(
   parameter int         NUM_LEDS   = 12,
   parameter int         T_BIT      = 50,
   parameter int         T0H        = 16,
   parameter int         T1H        = 32,
   parameter int         RES_CYCLES = 2400,
   parameter logic [2:0] COLOR_EN   = 3'b111
) (
   input  logic                clk,
   input  logic                res_n,
   input  logic [NUM_LEDS-1:0] led_mask,
   input  logic [7:0]          intensity,
   output logic                led_out,
   output logic                busy,
   output logic                frame_done
);
   localparam int CNT_MAX = (RES_CYCLES > T_BIT) ? RES_CYCLES : T_BIT;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int LED_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RES_CYCLES - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(T_BIT - 1);
   localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H);
   localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H);
   localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);

   typedef enum logic {LATCH = 1'b0, SEND = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [4:0]          bit_q, bit_d;
   logic [LED_W-1:0]    led_q, led_d, led_next;
   logic [23:0]         sr_q, sr_d;
   logic [NUM_LEDS-1:0] mask_q, mask_d;
   logic [7:0]          int_q, int_d;
   logic                led_out_q, led_out_d;
   logic                done_q, done_d;

   function automatic logic [23:0] led_word(input logic lit, input logic [7:0] level);
      led_word = {(lit && COLOR_EN[2]) ? level : 8'h00,
                  (lit && COLOR_EN[1]) ? level : 8'h00,
                  (lit && COLOR_EN[0]) ? level : 8'h00};
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      led_d    = led_q;
      sr_d     = sr_q;
      mask_d   = mask_q;
      int_d    = int_q;
      done_d   = 1'b0;
      led_next = (led_q == LED_LAST) ? '0 : led_q + 1'b1;

      case (state_q)
         LATCH: begin
            if (cnt_q == RES_LAST) begin
               // The first word comes straight from the live inputs, captured this same cycle.
               cnt_d   = '0;
               bit_d   = '0;
               led_d   = '0;
               mask_d  = led_mask;
               int_d   = intensity;
               sr_d    = led_word(led_mask[0], intensity);
               state_d = SEND;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SEND: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               sr_d  = {sr_q[22:0], 1'b0};
               if (bit_q == 5'd23) begin
                  bit_d = '0;
                  led_d = led_next;
                  sr_d  = led_word(mask_q[led_next], int_q);
                  if (led_q == LED_LAST) begin
                     state_d = LATCH;
                     done_d  = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = LATCH;
            cnt_d   = '0;
            bit_d   = '0;
            led_d   = '0;
         end
      endcase

      // Output is registered from next-state values so it lines up with state_q.
      led_out_d = (state_d == SEND) && (cnt_d < (sr_d[23] ? T1H_C : T0H_C));
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q   <= LATCH;
         cnt_q     <= '0;
         bit_q     <= '0;
         led_q     <= '0;
         sr_q      <= '0;
         mask_q    <= '0;
         int_q     <= '0;
         led_out_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         led_q     <= led_d;
         sr_q      <= sr_d;
         mask_q    <= mask_d;
         int_q     <= int_d;
         led_out_q <= led_out_d;
         done_q    <= done_d;
      end
   end

   assign led_out    = led_out_q;
   assign busy       = (state_q == SEND);
   assign frame_done = done_q;
endmodule

// File: tb/tb_ws2812b_driver.sv
// tb/tb_ws2812b_driver.sv - self-checking bench for ws2812b_driver (default and fast-timing instances).
module tb_ws2812b_driver;
   localparam int N      = 12;
   localparam int A_TBIT = 50;
   localparam int A_T0H  = 16;
   localparam int A_T1H  = 32;
   localparam int A_RES  = 2400;
   localparam int B_TBIT = 6;
   localparam int B_T0H  = 2;
   localparam int B_T1H  = 4;
   localparam int B_RES  = 12;
   localparam logic [2:0] B_CE = 3'b100;

   logic         clk;
   logic         rst_a, rst_b, sel;
   logic [N-1:0] mask;
   logic [7:0]   inten;
   logic         out_a, busy_a, done_a, out_b, busy_b, done_b;
   logic         obs_out, obs_busy, obs_done;
   int           checks = 0;
   int           errors = 0;
   logic [23:0]  dec_words [N];

   typedef struct {
      logic [N-1:0] mask;
      logic [7:0]   inten;
      logic [23:0]  lit_word;
   } vec_t;
   vec_t vecs [4];

   ws2812b_driver u_def (
      .clk(clk), .res_n(rst_a), .led_mask(mask), .intensity(inten),
      .led_out(out_a), .busy(busy_a), .frame_done(done_a)
   );

   ws2812b_driver #(
      .NUM_LEDS(N), .T_BIT(B_TBIT), .T0H(B_T0H), .T1H(B_T1H), .RES_CYCLES(B_RES), .COLOR_EN(B_CE)
   ) u_sml (
      .clk(clk), .res_n(rst_b), .led_mask(mask), .intensity(inten),
      .led_out(out_b), .busy(busy_b), .frame_done(done_b)
   );

   assign obs_out  = sel ? out_b  : out_a;
   assign obs_busy = sel ? busy_b : busy_a;
   assign obs_done = sel ? done_b : done_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] model_word(input logic [N-1:0] m, input logic [7:0] lvl,
                                              input logic [2:0] ce, input int i);
      logic [23:0] w;
      w = 24'h0;
      if (m[i])
         for (int k = 0; k < 3; k++)
            if (ce[2-k]) w[23-8*k -: 8] = lvl;
      return w;
   endfunction

   task automatic wait_busy(output int n, output int ndone, input int limit);
      n = 0;
      ndone = 0;
      do begin
         @(negedge clk);
         n++;
         if (obs_done !== 1'b0) ndone++;
      end while (obs_busy !== 1'b1 && n < limit);
   endtask

   // Entered on the first SEND sample; leaves on the first SEND sample of the next frame.
   task automatic run_frame(input string name, input int tbit, input int t0h, input int t1h,
                            input int res, input logic [2:0] ce, input int chg_at,
                            input logic [N-1:0] chg_mask, input logic [7:0] chg_int);
      logic [N-1:0] cm;
      logic [7:0]   ci;
      logic [23:0]  w;
      logic         exp_out, done_first, seen;
      int           send_len, led, b, ph, bad, hic, ngap, gbad;
      cm = mask;
      ci = inten;
      send_len = N * 24 * tbit;
      bad = 0;
      hic = 0;
      for (int t = 0; t < send_len; t++) begin
         if (t > 0) @(negedge clk);
         led = t / (24 * tbit);
         b   = (t / tbit) % 24;
         ph  = t % tbit;
         w   = model_word(cm, ci, ce, led);
         exp_out = (ph < (w[23-b] ? t1h : t0h));
         if (obs_out !== exp_out || obs_busy !== 1'b1 || obs_done !== 1'b0) bad++;
         if (obs_out === 1'b1) hic++;
         if (ph == tbit - 1) begin
            dec_words[led] = {dec_words[led][22:0], (hic > (t0h + t1h) / 2)};
            hic = 0;
         end
         if (t == chg_at) begin
            mask  = chg_mask;
            inten = chg_int;
         end
      end
      check({name, "_wave_bad_cycles"}, bad, 0);

      ngap = 0;
      gbad = 0;
      done_first = 1'b0;
      seen = 1'b0;
      while (!seen && ngap < res + 8) begin
         @(negedge clk);
         if (obs_busy === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (ngap == 0) done_first = obs_done;
            else if (obs_done !== 1'b0) gbad++;
            if (obs_out !== 1'b0) gbad++;
            if (send_len + ngap == chg_at) begin
               mask  = chg_mask;
               inten = chg_int;
            end
            ngap++;
         end
      end
      check({name, "_frame_done"}, done_first, 1);
      check({name, "_gap_len"}, ngap, res);
      check({name, "_gap_bad"}, gbad, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, nd, nd2, chg;
      logic [N-1:0] cur_m, nm;
      logic [7:0]   cur_i, ni;

      vecs[0] = '{12'h800, 8'h20, 24'h200000};
      vecs[1] = '{12'hFFF, 8'hA5, 24'hA50000};
      vecs[2] = '{12'h555, 8'h00, 24'h000000};
      vecs[3] = '{12'h001, 8'hFF, 24'hFF0000};

      sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
      mask = 12'h001; inten = 8'hFF;
      repeat (4) @(negedge clk);
      check("rst_led_out", obs_out, 0);
      check("rst_busy", obs_busy, 0);
      check("rst_frame_done", obs_done, 0);

      rst_a = 1'b1;
      wait_busy(n, nd, A_RES + 10);
      check("a_reset_gap", n, A_RES);
      check("a_reset_gap_done", nd, 0);
      check("a_first_high", obs_out, 1);

      run_frame("a1", A_TBIT, A_T0H, A_T1H, A_RES, 3'b111, 100 * A_TBIT + 7, 12'hFFF, 8'h01);
      for (int i = 0; i < N; i++)
         check($sformatf("a1_word%0d", i), dec_words[i], (i == 0) ? 24'hFFFFFF : 24'h000000);
      run_frame("a2", A_TBIT, A_T0H, A_T1H, A_RES, 3'b111, -1, '0, '0);
      for (int i = 0; i < N; i++)
         check($sformatf("a2_word%0d", i), dec_words[i], 24'h010101);

      rst_a = 1'b0;
      sel = 1'b1;
      mask = 12'hFFF; inten = 8'hFF;
      rst_b = 1'b1;
      wait_busy(n, nd, B_RES + 10);
      check("b_reset_gap", n, B_RES);
      repeat ((5 * 24 + 7) * B_TBIT + 1) @(negedge clk);
      check("b_pre_abort_out", obs_out, 1);
      rst_b = 1'b0;
      #1;
      check("b_abort_out", obs_out, 0);
      check("b_abort_busy", obs_busy, 0);
      nd = 0;
      repeat (5) begin
         @(negedge clk);
         if (obs_done !== 1'b0) nd++;
      end
      mask = vecs[0].mask; inten = vecs[0].inten;
      rst_b = 1'b1;
      wait_busy(n, nd2, B_RES + 10);
      check("b_abort_regap", n, B_RES);
      check("b_abort_no_done", nd + nd2, 0);

      nm = N'($urandom);
      ni = 8'($urandom);
      for (int v = 0; v < 4; v++) begin
         run_frame($sformatf("b_vec%0d", v), B_TBIT, B_T0H, B_T1H, B_RES, B_CE, N * 24 * B_TBIT + 1,
                   (v < 3) ? vecs[(v < 3) ? v + 1 : 0].mask  : nm,
                   (v < 3) ? vecs[(v < 3) ? v + 1 : 0].inten : ni);
         for (int i = 0; i < N; i++)
            check($sformatf("b_vec%0d_word%0d", v, i), dec_words[i],
                  vecs[v].mask[i] ? vecs[v].lit_word : 24'h000000);
      end

      cur_m = nm; cur_i = ni;
      for (int r = 0; r < 3; r++) begin
         nm  = N'($urandom);
         ni  = 8'($urandom);
         chg = int'($urandom_range(N * 24 * B_TBIT + B_RES - 1, 0));
         run_frame($sformatf("b_rnd%0d", r), B_TBIT, B_T0H, B_T1H, B_RES, B_CE, chg, nm, ni);
         for (int i = 0; i < N; i++)
            check($sformatf("b_rnd%0d_word%0d", r, i), dec_words[i], model_word(cur_m, cur_i, B_CE, i));
         cur_m = nm; cur_i = ni;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ws2812b_driver.md
Name: ws2812b_driver

Overview:
Downstream stage of the rotary/LED controller. It consumes the 12-bit LED mask and the 8-bit intensity word and serialises them onto a single WS2812B data line as a chain of NUM_LEDS 24-bit GRB words. Refresh runs continuously at 40 MHz. Inputs are snapshotted once per frame, so mask or intensity changes never tear a frame.

Parameters:
NUM_LEDS, 12, LEDs in the chain; width of led_mask.
T_BIT, 50, clock cycles per data bit (1.25 us at 40 MHz).
T0H, 16, high cycles for a 0 bit (0.40 us); low time is T_BIT-T0H.
T1H, 32, high cycles for a 1 bit (0.80 us); low time is T_BIT-T1H.
RES_CYCLES, 2400, low cycles of the latch/reset gap (60 us).
COLOR_EN, 3'b111, channel enables {G,R,B}; a disabled channel always sends 0x00.

Ports:
clk  in  1  system clock, 40 MHz
res_n  in  1  reset, asynchronous, active-low
led_mask  in  NUM_LEDS  bit i=1 lights LED i (LED 0 nearest the driver)
intensity  in  8  brightness applied to every enabled channel of a lit LED
led_out  out  1  WS2812B serial data line
busy  out  1  1 while bits are being sent (SEND state)
frame_done  out  1  one-cycle pulse on completion of the last bit of a frame

Behaviour:
- Reset (res_n low, any time, asynchronous): led_out=0, busy=0, frame_done=0, state=LATCH, all counters=0, snapshots=0. A reset mid-frame aborts the frame immediately. The line drops low.
- States: LATCH, SEND.
- LATCH:
  - led_out=0; a reset counter runs 0..RES_CYCLES-1.
  - On count RES_CYCLES-1: capture mask_q<=led_mask and int_q<=intensity, then load the LED 0 word into the 24-bit shift register and go to SEND.
  - LED i word = {G,R,B}, each channel = (mask bit i & COLOR_EN bit) ? intensity : 8'h00.
  - The captured values are used for the first word; all later words use mask_q/int_q.
- SEND:
  - A bit-cycle counter runs 0..T_BIT-1.
  - led_out=1 while cnt < (sr[23] ? T1H : T0H), else 0.
  - On cnt=T_BIT-1: shift sr left and increment the bit index (0..23).
  - After bit 23, increment the LED index and load the next word from mask_q/int_q.
  - After the last bit of LED NUM_LEDS-1, go to LATCH.
- Output timing: led_out is registered; the first high cycle appears the cycle after the LATCH count reaches RES_CYCLES-1.
- Order: LED 0 first; within a word G7..G0, R7..R0, B7..B0 (MSB first).
- frame_done: asserted for exactly the first cycle in LATCH following a completed SEND. It is never asserted after reset or after an aborted frame.
- busy: 1 in every SEND cycle, 0 in LATCH.
- Frame period = RES_CYCLES + NUM_LEDS*24*T_BIT = 2400 + 14400 = 16800 cycles, repeating indefinitely.
- led_mask/intensity changes during SEND or LATCH (before the capture cycle) take effect at the next capture only.
- intensity=0 with LEDs lit: all bits are 0-codes; the frame is still sent.
- Counters saturate nowhere. The bit/LED indices wrap to 0 on frame end. No illegal state is reachable; the default branch goes to LATCH.

Test Plan:
- Reset: hold res_n=0 -> led_out=0, busy=0, frame_done=0. Release -> led_out stays 0 for exactly 2400 cycles, then rises; busy rises on the same cycle.
- Bit timing: led_mask=12'h001, intensity=8'hFF -> LED 0's first 24 bits are 1-codes (32 high/18 low). All remaining 264 bits are 0-codes (16 high/34 low).
- Frame content: led_mask=12'h800, intensity=8'h20, COLOR_EN=3'b100 -> only LED 11 word is non-zero and equals 24'h200000. Decoded bitstream matches bit-for-bit.
- Snapshot: change led_mask 12'h001->12'h002 during bit 100 of a frame -> current frame shows LED 0 lit; next frame shows LED 1 lit. frame_done pulses once per 16800 cycles.
- Mid-frame reset: assert res_n=0 at LED 5 bit 7 -> led_out=0 within the same cycle (async). No frame_done. After release, a full 2400-cycle gap precedes the next frame.
- Intensity map: intensity=8'h01, mask=12'hFFF -> every word is 24'h010101; frame length is exactly 14400 busy cycles.
